// File: rtl/alu_operand_sequencer.sv
// Control stage for the 4-bit ALU datapath. The user enters A, B, the
// operation select and the shift amounts from four slide switches, stepping
// with a debounced Enter button and going back with a debounced Back button.
// The block then waits for the ALU outputs to settle and captures the result
// and flags for display.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   Sw[3:0]                  raw slide switches, sampled when a button press is accepted
//   Btn_Enter, Btn_Back      raw bouncy push buttons
//   Alu_Res, Alu_Flags       combinational ALU outputs {Cero, Negativo, C_out, Overflow}
//   A, B, OP, OP_S           registered ALU operands and operation selects
//   Shift_R, Shift_L         registered shift amounts
//   Res_Q, Flags_Q, Valid    captured ALU result, captured flags, capture-valid flag
//   Step                     current state encoding, shown on LEDs
module alu_operand_sequencer #(
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Sw,
  input  logic       Btn_Enter,
  input  logic       Btn_Back,
  input  logic [3:0] Alu_Res,
  input  logic [3:0] Alu_Flags,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [1:0] OP,
  output logic [1:0] OP_S,
  output logic [1:0] Shift_R,
  output logic [1:0] Shift_L,
  output logic [3:0] Res_Q,
  output logic [3:0] Flags_Q,
  output logic       Valid,
  output logic [2:0] Step
);

  localparam int unsigned DB_W  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_SH   = 3'd3,
    S_EXEC = 3'd4,
    S_SHOW = 3'd5
  } state_t;

  // Button conditioning, bit 0 = Enter, bit 1 = Back
  logic [1:0]      btn_raw;
  logic [1:0]      meta_q, sync_q;
  logic [1:0]      cand_q, cand_d;
  logic [1:0]      level_q, level_d;
  logic [1:0]      prev_q;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  logic            enter_pulse_c, back_pulse_c;

  assign btn_raw = {Btn_Back, Btn_Enter};

  // Debounce: any change of the synchronized level restarts the count; a level
  // that stays put long enough becomes the accepted level.
  always_comb begin
    cand_d  = cand_q;
    level_d = level_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync_q[i] != cand_q[i]) begin
        cand_d[i]   = sync_q[i];
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
        level_d[i] = cand_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      cand_q  <= '0;
      level_q <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      meta_q  <= btn_raw;
      sync_q  <= meta_q;
      cand_q  <= cand_d;
      level_q <= level_d;
      prev_q  <= level_q;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // One pulse per accepted rising edge, so holding a button advances once
  assign enter_pulse_c = level_q[0] & ~prev_q[0];
  assign back_pulse_c  = level_q[1] & ~prev_q[1];

  // Sequencer registers
  state_t           state_q, state_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d, ops_q, ops_d;
  logic [1:0]       sr_q, sr_d, sl_q, sl_d;
  logic [3:0]       res_q, res_d, flags_q, flags_d;
  logic             valid_q, valid_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      ops_q     <= '0;
      sr_q      <= '0;
      sl_q      <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      valid_q   <= 1'b0;
      set_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      ops_q     <= ops_d;
      sr_q      <= sr_d;
      sl_q      <= sl_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      valid_q   <= valid_d;
      set_cnt_q <= set_cnt_d;
    end
  end

  // Next-state logic; Back takes priority over a same-cycle Enter
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    ops_d     = ops_q;
    sr_d      = sr_q;
    sl_d      = sl_q;
    res_d     = res_q;
    flags_d   = flags_q;
    valid_d   = valid_q;
    set_cnt_d = set_cnt_q;
    case (state_q)
      S_A: begin
        if (enter_pulse_c && !back_pulse_c) begin
          a_d     = Sw;
          state_d = S_B;
        end
      end
      S_B: begin
        if (back_pulse_c) begin
          state_d = S_A;
        end else if (enter_pulse_c) begin
          b_d     = Sw;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (back_pulse_c) begin
          state_d = S_B;
        end else if (enter_pulse_c) begin
          op_d    = Sw[1:0];
          ops_d   = Sw[3:2];
          state_d = S_SH;
        end
      end
      S_SH: begin
        if (back_pulse_c) begin
          state_d = S_OP;
        end else if (enter_pulse_c) begin
          sr_d      = Sw[1:0];
          sl_d      = Sw[3:2];
          set_cnt_d = '0;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        // Capture on the last settle cycle so EXEC lasts SETTLE_CYCLES cycles
        if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          res_d   = Alu_Res;
          flags_d = Alu_Flags;
          valid_d = 1'b1;
          state_d = S_SHOW;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end
      S_SHOW: begin
        if (back_pulse_c) begin
          valid_d = 1'b0;
          state_d = S_SH;
        end else if (enter_pulse_c) begin
          valid_d = 1'b0;
          state_d = S_A;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_A;
      end
    endcase
  end

  assign A       = a_q;
  assign B       = b_q;
  assign OP      = op_q;
  assign OP_S    = ops_q;
  assign Shift_R = sr_q;
  assign Shift_L = sl_q;
  assign Res_Q   = res_q;
  assign Flags_Q = flags_q;
  assign Valid   = valid_q;
  assign Step    = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed scenarios plus
// random button/switch sequences, checked against a step-level model.
module tb_alu_operand_sequencer;

  localparam int unsigned DB     = 4;
  localparam int unsigned SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Sw;
  logic       Btn_Enter, Btn_Back;
  logic [3:0] Alu_Res, Alu_Flags;
  logic [3:0] A, B, Res_Q, Flags_Q;
  logic [1:0] OP, OP_S, Shift_R, Shift_L;
  logic       Valid;
  logic [2:0] Step;

  int checks   = 0;
  int failures = 0;
  int valid_bad = 0;

  // Sequencer model state
  int m_step, m_a, m_b, m_op, m_ops, m_sr, m_sl, m_res, m_flags, m_valid;

  alu_operand_sequencer #(.DB_CYCLES(DB), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .Sw(Sw), .Btn_Enter(Btn_Enter), .Btn_Back(Btn_Back),
    .Alu_Res(Alu_Res), .Alu_Flags(Alu_Flags), .A(A), .B(B), .OP(OP), .OP_S(OP_S),
    .Shift_R(Shift_R), .Shift_L(Shift_L), .Res_Q(Res_Q), .Flags_Q(Flags_Q),
    .Valid(Valid), .Step(Step)
  );

  always #5 clk = ~clk;

  // ALU behaviour: shift A first, then combine with B. Returns {flags, result}.
  function automatic logic [7:0] alu_f(input int a, input int b, input int op,
                                       input int ops, input int sr, input int sl);
    int x, r, c, v;
    x = a;
    if (ops == 1) x = a >> sr;
    else if (ops == 2) x = (a << sl) & 15;
    c = 0;
    v = 0;
    case (op)
      0: begin
        r = x + b;
        c = (r >> 4) & 1;
        r = r & 15;
        v = (((x >> 3) == (b >> 3)) && ((r >> 3) != (x >> 3))) ? 1 : 0;
      end
      1: begin
        r = x + ((~b) & 15) + 1;
        c = (r >> 4) & 1;
        r = r & 15;
        v = (((x >> 3) != (b >> 3)) && ((r >> 3) != (x >> 3))) ? 1 : 0;
      end
      2: r = x | b;
      default: r = x & b;
    endcase
    return 8'((((r == 0) ? 1 : 0) << 7) | (((r >> 3) & 1) << 6) | (c << 5) | (v << 4) | r);
  endfunction

  always_comb {Alu_Flags, Alu_Res} = alu_f(int'(A), int'(B), int'(OP), int'(OP_S),
                                           int'(Shift_R), int'(Shift_L));

  always @(negedge clk) if (!rst && Valid && Step != 3'd5) valid_bad++;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ":Step"},    32'(Step),    m_step);
    check_eq({tag, ":A"},       32'(A),       m_a);
    check_eq({tag, ":B"},       32'(B),       m_b);
    check_eq({tag, ":OP"},      32'(OP),      m_op);
    check_eq({tag, ":OP_S"},    32'(OP_S),    m_ops);
    check_eq({tag, ":Shift_R"}, 32'(Shift_R), m_sr);
    check_eq({tag, ":Shift_L"}, 32'(Shift_L), m_sl);
    check_eq({tag, ":Res_Q"},   32'(Res_Q),   m_res);
    check_eq({tag, ":Flags_Q"}, 32'(Flags_Q), m_flags);
    check_eq({tag, ":Valid"},   32'(Valid),   m_valid);
  endtask

  task automatic model_reset();
    m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_ops = 0;
    m_sr = 0; m_sl = 0; m_res = 0; m_flags = 0; m_valid = 0;
  endtask

  // One accepted press: Back wins over Enter
  task automatic model_press(input bit e, input bit bk, input int sw);
    logic [7:0] out;
    if (bk) begin
      case (m_step)
        1: m_step = 0;
        2: m_step = 1;
        3: m_step = 2;
        5: begin m_valid = 0; m_step = 3; end
        default: ;
      endcase
    end else if (e) begin
      case (m_step)
        0: begin m_a = sw; m_step = 1; end
        1: begin m_b = sw; m_step = 2; end
        2: begin m_op = sw & 3; m_ops = (sw >> 2) & 3; m_step = 3; end
        3: begin
          m_sr = sw & 3;
          m_sl = (sw >> 2) & 3;
          out = alu_f(m_a, m_b, m_op, m_ops, m_sr, m_sl);
          m_res = int'(out[3:0]);
          m_flags = int'(out[7:4]);
          m_valid = 1;
          m_step = 5;
        end
        5: begin m_valid = 0; m_step = 0; end
        default: ;
      endcase
    end
  endtask

  // Hold the buttons long enough to be accepted, release, then compare
  task automatic press(input bit e, input bit bk, input int sw, input string tag);
    int ex;
    bit to_exec;
    to_exec = (m_step == 3) && e && !bk;
    @(negedge clk);
    Sw = 4'(sw);
    Btn_Enter = e;
    Btn_Back = bk;
    ex = 0;
    repeat (12) begin @(negedge clk); if (Step == 3'd4) ex++; end
    Btn_Enter = 1'b0;
    Btn_Back = 1'b0;
    repeat (12) begin @(negedge clk); if (Step == 3'd4) ex++; end
    model_press(e, bk, sw);
    check_all(tag);
    if (to_exec) check_eq({tag, ":exec_cycles"}, 32'(ex), int'(SETTLE));
  endtask

  initial begin
    rst = 1'b1;
    Sw = '0;
    Btn_Enter = 1'b0;
    Btn_Back = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all("post_reset");

    // Add 3 + 4
    press(1, 0, 3, "add_a");
    press(1, 0, 4, "add_b");
    press(1, 0, 0, "add_op");
    press(1, 0, 0, "add_sh");
    check_eq("add_res", 32'(Res_Q), 7);
    check_eq("add_flags", 32'(Flags_Q), 0);
    press(1, 0, 0, "add_done");

    // Subtract 8 - 1 overflows
    press(1, 0, 8, "sub_a");
    press(1, 0, 1, "sub_b");
    press(1, 0, 1, "sub_op");
    press(1, 0, 0, "sub_sh");
    check_eq("sub_res", 32'(Res_Q), 7);
    check_eq("sub_ovf", 32'(Flags_Q[0]), 1);
    press(1, 0, 0, "sub_done");
    press(0, 1, 0, "back_in_a");

    // Bouncing Enter, then a clean hold: a single advance
    @(negedge clk);
    Sw = 4'd5;
    for (int i = 0; i < 10; i++) begin
      Btn_Enter = ~Btn_Enter;
      repeat (2) @(negedge clk);
    end
    check_eq("bounce_no_step", 32'(Step), m_step);
    Btn_Enter = 1'b1;
    repeat (12) @(negedge clk);
    Btn_Enter = 1'b0;
    repeat (12) @(negedge clk);
    model_press(1, 0, 5);
    check_all("bounce");

    // Back navigation
    press(1, 0, 2, "nav_b");
    press(0, 1, 0, "nav_back1");
    press(0, 1, 0, "nav_back2");
    press(1, 0, 9, "nav_reload_a");
    check_eq("nav_b_kept", 32'(B), 2);
    press(1, 1, 6, "both_in_b");

    // Re-execute with a left shift
    press(1, 0, 3, "rx_a");
    press(1, 0, 6, "rx_b");
    press(1, 0, 8, "rx_op");
    press(1, 0, 0, "rx_sh");
    press(0, 1, 0, "rx_back");
    press(1, 0, 4, "rx_sh2");
    check_eq("rx_shl", 32'(Shift_L), 1);
    check_eq("rx_res", 32'(Res_Q), (6 + m_b) % 16);

    // Asynchronous reset mid-S_OP
    press(1, 0, 0, "rst_leave_show");
    press(1, 0, 7, "rst_a");
    press(1, 0, 9, "rst_b");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_all("rst_release");

    // Random sequences
    for (int n = 0; n < 40; n++) begin
      int act;
      int sw;
      act = int'($urandom_range(0, 9));
      sw = int'($urandom_range(0, 15));
      press((act < 7) || (act == 9), act >= 7, sw, $sformatf("rnd%0d", n));
    end

    check_eq("valid_only_in_show", 32'(valid_bad), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
